// File: rtl/tbec_rsc_encoder_pipe.sv
// Two-stage, multi-lane TBEC-RSC encoder (16-bit words -> 32-bit codewords) with valid/ready handshakes.
// Fault injection (FSM, mask, inj_count_o) is built only when TBEC_FAULT_INJECT_EN is defined.
module tbec_rsc_encoder_pipe #(
  parameter int NUM_LANES  = 4,
  parameter int INJ_PERIOD = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              in_valid_i,
  output logic                                              in_ready_o,
  input  logic [16*NUM_LANES-1:0]                           in_data_i,
  output logic                                              out_valid_o,
  input  logic                                              out_ready_i,
  output logic [32*NUM_LANES-1:0]                           out_data_o,
  input  logic [1:0]                                        inj_mode_i,
  input  logic [6:0]                                        inj_pattern_i,
  input  logic [4:0]                                        inj_pos_i,
  input  logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] inj_lane_i,
  output logic [31:0]                                       cw_count_o,
  output logic [15:0]                                       inj_count_o
);

  localparam int DW = 32 * NUM_LANES;

  // d[15] is bit index 0; s[g][k] is index 4g+k.
  function automatic logic [31:0] encode_lane(input logic [15:0] d);
    logic [3:0][3:0] s;
    logic [15:0]     sys;
    logic [3:0]      p;
    logic [3:0]      di;
    logic [7:0]      cb;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        s[g][k] = d[15-(4*g+k)];
      end
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < 4; g++) begin
        sys[15-(4*k+g)] = s[g][k];
      end
    end
    p[0]  = s[0][0] ^ s[0][1] ^ s[1][0] ^ s[1][1];
    p[1]  = s[2][0] ^ s[2][1] ^ s[3][0] ^ s[3][1];
    p[2]  = s[0][2] ^ s[0][3] ^ s[1][2] ^ s[1][3];
    p[3]  = s[2][2] ^ s[2][3] ^ s[3][2] ^ s[3][3];
    di[0] = s[0][0] ^ s[1][1] ^ s[2][0] ^ s[3][1];
    di[1] = s[0][1] ^ s[1][0] ^ s[2][1] ^ s[3][0];
    di[2] = s[0][2] ^ s[1][3] ^ s[2][2] ^ s[3][3];
    di[3] = s[0][3] ^ s[1][2] ^ s[2][3] ^ s[3][2];
    for (int g = 0; g < 4; g++) begin
      cb[7-2*g] = s[g][0] ^ s[g][2];
      cb[6-2*g] = s[g][1] ^ s[g][3];
    end
    return {sys, di[0], di[3], di[1], di[2], p[0], p[3], p[1], p[2], cb};
  endfunction

  logic          s1_valid_q;
  logic [DW-1:0] s1_cw_q;
  logic [DW-1:0] s1_mask_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [31:0]   cw_count_q;
  logic [DW-1:0] enc_s;
  logic [DW-1:0] mask_s;
  logic          s2_adv_s;
  logic          in_ready_s;
  logic          in_fire_s;
  logic          out_fire_s;

  assign s2_adv_s   = !out_valid_q || out_ready_i;
  assign in_ready_s = !s1_valid_q || s2_adv_s;
  assign in_fire_s  = in_valid_i && in_ready_s;
  assign out_fire_s = out_valid_q && out_ready_i;

  always_comb begin
    enc_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      enc_s[32*l +: 32] = encode_lane(in_data_i[16*l +: 16]);
    end
  end

`ifdef TBEC_FAULT_INJECT_EN
  typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_CONT, ST_PERIODIC} inj_state_t;

  inj_state_t  state_q;
  logic [1:0]  mode_q;
  logic [15:0] per_cnt_q;
  logic        s1_inj_q;
  logic        out_inj_q;
  logic [15:0] inj_count_q;
  logic [31:0] lane_mask_s;
  logic        lane_ok_s;
  logic        hit_s;
  logic        corrupt_s;

  assign lane_mask_s = {25'b0, inj_pattern_i} << inj_pos_i;
  assign lane_ok_s   = 32'(inj_lane_i) < 32'(NUM_LANES);
  assign corrupt_s   = hit_s && lane_ok_s && (lane_mask_s != 32'd0);

  always_comb begin
    case (state_q)
      ST_ARMED:    hit_s = 1'b1;
      ST_CONT:     hit_s = 1'b1;
      ST_PERIODIC: hit_s = (per_cnt_q == 16'(INJ_PERIOD - 1));
      default:     hit_s = 1'b0;
    endcase
  end

  always_comb begin
    mask_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (hit_s && (32'(inj_lane_i) == 32'(l))) begin
        mask_s[32*l +: 32] = lane_mask_s;
      end else begin
        mask_s[32*l +: 32] = 32'd0;
      end
    end
  end

  // A mode change re-enters the matching state; otherwise accepted beats drive the transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      mode_q    <= 2'b00;
      per_cnt_q <= 16'd0;
    end else begin
      mode_q <= inj_mode_i;
      if (inj_mode_i != mode_q) begin
        per_cnt_q <= 16'd0;
        case (inj_mode_i)
          2'b01:   state_q <= ST_ARMED;
          2'b10:   state_q <= ST_CONT;
          2'b11:   state_q <= ST_PERIODIC;
          default: state_q <= ST_OFF;
        endcase
      end else if (in_fire_s) begin
        case (state_q)
          ST_ARMED:    state_q <= ST_OFF;
          ST_PERIODIC: per_cnt_q <= hit_s ? 16'd0 : per_cnt_q + 16'd1;
          default:     state_q <= state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_inj_q    <= 1'b0;
      out_inj_q   <= 1'b0;
      inj_count_q <= 16'd0;
    end else begin
      if (in_fire_s) begin
        s1_inj_q <= corrupt_s;
      end
      if (s2_adv_s && s1_valid_q) begin
        out_inj_q <= s1_inj_q;
      end
      if (out_fire_s && out_inj_q && (inj_count_q != 16'hFFFF)) begin
        inj_count_q <= inj_count_q + 16'd1;
      end
    end
  end

  assign inj_count_o = inj_count_q;
`else
  logic unused_inj_s;

  assign mask_s       = '0;
  assign inj_count_o  = 16'd0;
  assign unused_inj_s = ^{inj_mode_i, inj_pattern_i, inj_pos_i, inj_lane_i};
`endif

  // Stage 1 holds codewords and mask; stage 2 holds the corrupted codeword presented downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_mask_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cw_count_q  <= 32'd0;
    end else begin
      if (in_ready_s) begin
        s1_valid_q <= in_valid_i;
        if (in_valid_i) begin
          s1_cw_q   <= enc_s;
          s1_mask_q <= mask_s;
        end
      end
      if (s2_adv_s) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= s1_cw_q ^ s1_mask_q;
        end
      end
      if (out_fire_s) begin
        cw_count_q <= cw_count_q + 32'd1;
      end
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign cw_count_o  = cw_count_q;

endmodule

// File: tb/tb_tbec_rsc_encoder_pipe.sv
// Scoreboard bench for tbec_rsc_encoder_pipe: expected codewords are queued at each input
// handshake from an independent mask-based encoder model and compared at each output handshake.
module tb_tbec_rsc_encoder_pipe;
  localparam int NL = 4;
  localparam int IP = 4;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;
  localparam int DW = 32 * NL;
`ifdef TBEC_FAULT_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [16*NL-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [1:0]      inj_mode = 2'b00;
  logic [6:0]      inj_pattern = 7'd0;
  logic [4:0]      inj_pos = 5'd0;
  logic [LW-1:0]   inj_lane = '0;
  logic [31:0]     cw_count;
  logic [15:0]     inj_count;

  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   exp_q[$];
  bit              exp_inj_q[$];
  logic [31:0]     exp_cw = 32'd0;
  logic [15:0]     exp_inj = 16'd0;
  bit              plan_inj = 1'b0;
  bit              accepted = 1'b0;
  bit              hold_pend = 1'b0;
  logic [DW-1:0]   held = '0;

  tbec_rsc_encoder_pipe #(.NUM_LANES(NL), .INJ_PERIOD(IP)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .inj_mode_i(inj_mode), .inj_pattern_i(inj_pattern), .inj_pos_i(inj_pos), .inj_lane_i(inj_lane),
    .cw_count_o(cw_count), .inj_count_o(inj_count)
  );

  always #5 clk = ~clk;

  // Parity terms expressed as XOR-reductions over fixed bit masks of the data word.
  function automatic logic [31:0] model_cw(input logic [15:0] d);
    logic [31:0] c;
    c = 32'd0;
    for (int j = 0; j < 16; j++) begin
      c[31-j] = d[15-(4*(j%4)+(j/4))];
    end
    c[15] = ^(d & 16'h8484); c[14] = ^(d & 16'h1212);
    c[13] = ^(d & 16'h4848); c[12] = ^(d & 16'h2121);
    c[11] = ^(d & 16'hCC00); c[10] = ^(d & 16'h0033);
    c[9]  = ^(d & 16'h00CC); c[8]  = ^(d & 16'h3300);
    c[7]  = ^(d & 16'hA000); c[6]  = ^(d & 16'h5000);
    c[5]  = ^(d & 16'h0A00); c[4]  = ^(d & 16'h0500);
    c[3]  = ^(d & 16'h00A0); c[2]  = ^(d & 16'h0050);
    c[1]  = ^(d & 16'h000A); c[0]  = ^(d & 16'h0005);
    return c;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    logic [31:0]   m;
    logic [DW-1:0] e;
    bit            hit;
    m   = {25'b0, inj_pattern} << inj_pos;
    hit = plan_inj && INJ_EN && (int'(inj_lane) < NL);
    for (int l = 0; l < NL; l++) begin
      e[32*l +: 32] = model_cw(in_data[16*l +: 16]) ^ ((hit && (int'(inj_lane) == l)) ? m : 32'd0);
    end
    exp_q.push_back(e);
    exp_inj_q.push_back(hit && (m != 32'd0));
  endtask

  // One clock: sample at negedge, score handshakes, then step to just after the rising edge.
  task automatic tick();
    logic [DW-1:0] e;
    bit            ei;
    @(negedge clk);
    accepted = 1'b0;
    check("cw_count", DW'(cw_count), DW'(exp_cw));
    check("inj_count", DW'(inj_count), DW'(exp_inj));
    if (hold_pend) begin
      check("hold_valid", DW'(out_valid), DW'(1));
      check("hold_data", out_data, held);
    end
    if (in_valid && in_ready) begin
      push_expected();
      accepted = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", DW'(out_valid), DW'(0));
      end else begin
        e  = exp_q.pop_front();
        ei = exp_inj_q.pop_front();
        check("out_data", out_data, e);
        exp_cw = exp_cw + 32'd1;
        if (ei && exp_inj != 16'hFFFF) exp_inj = exp_inj + 16'd1;
      end
    end
    hold_pend = out_valid && !out_ready;
    held      = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16*NL-1:0] d, input bit inj);
    in_valid = 1'b1;
    in_data  = d;
    plan_inj = inj;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (accepted) break;
    end
    check("send_accepted", DW'(accepted), DW'(1));
    in_valid = 1'b0;
    plan_inj = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_queue_empty", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    inj_mode = 2'b00;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_inj_q.delete();
    exp_cw    = 32'd0;
    exp_inj   = 16'd0;
    hold_pend = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_cw_count", DW'(cw_count), DW'(0));
    check("rst_inj_count", DW'(inj_count), DW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Directed encodes: lane0 0x8000, lane1 0xFFFF, lane2 0x0000, lane3 arbitrary.
    send({16'h1234, 16'h0000, 16'hFFFF, 16'h8000}, 1'b0);
    send({16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF}, 1'b0);
    send({16'hA5C3, 16'h0001, 16'h8000, 16'h0000}, 1'b0);
    drain();

    // One-shot: first zero beat gets 0x30 in lane 0, the second stays clean.
    do_reset();
    inj_mode = 2'b01; inj_pattern = 7'h03; inj_pos = 5'd4; inj_lane = LW'(0);
    tick(); tick();
    send('0, 1'b1);
    send('0, 1'b0);
    drain();
    check("oneshot_inj_count", DW'(inj_count), DW'(INJ_EN ? 1 : 0));
    check("oneshot_cw_count", DW'(cw_count), DW'(2));
    inj_mode = 2'b00;
    tick();

    // Continuous: pattern 0x7F at pos 30 leaves only bits 31:30 in lane 0.
    inj_mode = 2'b10; inj_pattern = 7'h7F; inj_pos = 5'd30; inj_lane = LW'(0);
    tick(); tick();
    send('0, 1'b1);
    send('0, 1'b1);
    send({$urandom, $urandom}, 1'b1);
    drain();
    inj_mode = 2'b00;
    tick();

    // Periodic with period 4: beats 4, 8 and 12 corrupted.
    do_reset();
    inj_mode = 2'b11; inj_pattern = 7'h55; inj_pos = 5'd3; inj_lane = LW'(2);
    tick(); tick();
    for (int i = 0; i < 12; i++) send({$urandom, $urandom}, (i % 4) == 3);
    drain();
    check("periodic_cw_count", DW'(cw_count), DW'(12));
    check("periodic_inj_count", DW'(inj_count), DW'(INJ_EN ? 3 : 0));
    inj_mode = 2'b00;
    tick();

    // Backpressure: two beats accepted, then in_ready low while the sink stalls.
    out_ready = 1'b0;
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b0);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", DW'(in_ready), DW'(0));
      tick();
    end
    out_ready = 1'b1;
    send(in_data, 1'b0);
    drain();

    // Random valid/ready traffic, including simultaneous in/out handshakes.
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      tick();
    end
    drain();

    // Reset with two beats in flight: nothing emerges afterwards.
    out_ready = 1'b0;
    send({$urandom, $urandom}, 1'b0);
    send({$urandom, $urandom}, 1'b0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("post_reset_quiet", DW'(out_valid), DW'(0));
      tick();
    end
    check("post_reset_cw_count", DW'(cw_count), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
